lif_neuron_array: RTL and testbench

- Parametrised, time-multiplexed leaky integrate-and-fire (LIF) neuron array for the neural_navigators Tiny Tapeout design.
- Sits between the ui_in/uio pin decode and the uo_out spike mux.
- Per step, it consumes one input-spike vector, updates every membrane potential sequentially (one neuron per cycle), and publishes an output-spike vector.
- Generalises the fixed single-neuron datapath to NUM_NEURONS channels, WIDTH-bit state, signed weights and a configurable leak.

---
 rtl/lif_pkg.sv | 22 ++
 rtl/lif_neuron_array_if.sv | 28 ++
 rtl/lif_update.sv | 57 +++++
 rtl/lif_neuron_array.sv | 129 ++++++++++++
 tb/tb_lif_neuron_array.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron array.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } lif_state_e;

    localparam logic CFG_SEL_WEIGHT = 1'b0;
    localparam logic CFG_SEL_THRESH = 1'b1;

    // Two extra bits hold the sign and the carry of V - leak + weight.
    function automatic int clamp_w(input int width);
        return width + 2;
    endfunction

    function automatic int refrac_cnt_w(input int steps);
        return (steps < 1) ? 1 : $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Step handshake, spike output and configuration bus of the LIF neuron array.
interface lif_neuron_array_if #(
    parameter int NUM_NEURONS = 4,
    parameter int WIDTH       = 8
);
    localparam int ADDR_W = $clog2(NUM_NEURONS);

    logic                   step_valid;
    logic                   step_ready;
    logic [NUM_NEURONS-1:0] in_spikes;
    logic                   out_valid;
    logic [NUM_NEURONS-1:0] out_spikes;
    logic                   cfg_we;
    logic                   cfg_sel;
    logic [ADDR_W-1:0]      cfg_addr;
    logic [WIDTH-1:0]       cfg_data;
    logic                   cfg_err;

    modport master (
        output step_valid, in_spikes, cfg_we, cfg_sel, cfg_addr, cfg_data,
        input  step_ready, out_valid, out_spikes, cfg_err
    );

    modport slave (
        input  step_valid, in_spikes, cfg_we, cfg_sel, cfg_addr, cfg_data,
        output step_ready, out_valid, out_spikes, cfg_err
    );
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron leak/integrate/fire datapath.
// LIF_REFRACTORY_EN adds the refractory counter ports.
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int LEAK_SHIFT   = 3,
    parameter int REFRAC_STEPS = 2,
    localparam int CNT_W       = refrac_cnt_w(REFRAC_STEPS)
) (
    input  logic [WIDTH-1:0]        v,
    input  logic signed [WIDTH-1:0] weight,
    input  logic                    spike,
    input  logic [WIDTH-1:0]        threshold,
`ifdef LIF_REFRACTORY_EN
    input  logic [CNT_W-1:0]        cnt,
    output logic [CNT_W-1:0]        cnt_next,
`endif
    output logic [WIDTH-1:0]        v_next,
    output logic                    fire
);
    localparam int DW = clamp_w(WIDTH);
    localparam logic signed [DW-1:0] VMAX = {2'b00, {WIDTH{1'b1}}};

    logic [WIDTH-1:0]     leak;
    logic signed [DW-1:0] t;
    logic [WIDTH-1:0]     t_clamp;

    always_comb begin
        leak = (LEAK_SHIFT == 0) ? '0 : (v >> LEAK_SHIFT);
        t    = $signed({2'b00, v}) - $signed({2'b00, leak});
        if (spike)
            t = t + $signed({{2{weight[WIDTH-1]}}, weight});

        if (t < 0)
            t_clamp = '0;
        else if (t > VMAX)
            t_clamp = '1;
        else
            t_clamp = t[WIDTH-1:0];

        fire   = (t_clamp >= threshold);
        v_next = fire ? '0 : t_clamp;
`ifdef LIF_REFRACTORY_EN
        cnt_next = cnt;
        // A refractory neuron keeps its potential untouched and stays silent.
        if (cnt != '0) begin
            v_next   = v;
            fire     = 1'b0;
            cnt_next = cnt - CNT_W'(1);
        end else if (fire) begin
            cnt_next = CNT_W'(REFRAC_STEPS);
        end
`endif
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: one neuron updated per cycle, one spike
// vector out per step. LIF_REFRACTORY_EN enables per-neuron refractory counters.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS  = 4,
    parameter int WIDTH        = 8,
    parameter int LEAK_SHIFT   = 3,
    parameter int THRESH_INIT  = 200,
    parameter int REFRAC_STEPS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    lif_neuron_array_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_NEURONS);
    localparam int CNT_W  = refrac_cnt_w(REFRAC_STEPS);

    lif_state_e                         state;
    logic [ADDR_W-1:0]                  idx;
    logic [NUM_NEURONS-1:0]             spikes_q;
    logic [NUM_NEURONS-1:0]             scratch_q;
    logic [NUM_NEURONS-1:0]             scratch_nx;
    logic [NUM_NEURONS-1:0][WIDTH-1:0]  v_q;
    logic [NUM_NEURONS-1:0][WIDTH-1:0]  w_q;
    logic [WIDTH-1:0]                   thresh_q;
    logic [NUM_NEURONS-1:0]             out_spikes_q;
    logic                               out_valid_q;
    logic                               cfg_err_q;
    logic [WIDTH-1:0]                   v_next;
    logic                               fire;
    logic                               addr_ok;
    logic                               cfg_ok;
    logic                               cfg_bad;
`ifdef LIF_REFRACTORY_EN
    logic [NUM_NEURONS-1:0][CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]                   cnt_next;
`endif

    assign bus.step_ready = (state == IDLE);
    assign bus.out_spikes = out_spikes_q;
    // Pulses are masked while disabled but the registers themselves are frozen.
    assign bus.out_valid  = out_valid_q & ena;
    assign bus.cfg_err    = cfg_err_q & ena;

    assign addr_ok = int'(bus.cfg_addr) < NUM_NEURONS;
    assign cfg_ok  = bus.cfg_we && (state == IDLE) &&
                     ((bus.cfg_sel == CFG_SEL_THRESH) || addr_ok);
    assign cfg_bad = bus.cfg_we && !cfg_ok;

    lif_update #(
        .WIDTH        (WIDTH),
        .LEAK_SHIFT   (LEAK_SHIFT),
        .REFRAC_STEPS (REFRAC_STEPS)
    ) u_update (
        .v         (v_q[idx]),
        .weight    (w_q[idx]),
        .spike     (spikes_q[idx]),
        .threshold (thresh_q),
`ifdef LIF_REFRACTORY_EN
        .cnt       (cnt_q[idx]),
        .cnt_next  (cnt_next),
`endif
        .v_next    (v_next),
        .fire      (fire)
    );

    always_comb begin
        scratch_nx      = scratch_q;
        scratch_nx[idx] = fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            spikes_q     <= '0;
            scratch_q    <= '0;
            v_q          <= '0;
            w_q          <= '0;
            thresh_q     <= WIDTH'(THRESH_INIT);
            out_spikes_q <= '0;
            out_valid_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
`ifdef LIF_REFRACTORY_EN
            cnt_q        <= '0;
`endif
        end else if (ena) begin
            out_valid_q <= 1'b0;
            cfg_err_q   <= cfg_bad;

            if (cfg_ok) begin
                if (bus.cfg_sel == CFG_SEL_THRESH)
                    thresh_q <= bus.cfg_data;
                else
                    w_q[bus.cfg_addr] <= bus.cfg_data;
            end

            case (state)
                IDLE: begin
                    if (bus.step_valid) begin
                        spikes_q <= bus.in_spikes;
                        idx      <= '0;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    v_q[idx]  <= v_next;
                    scratch_q <= scratch_nx;
`ifdef LIF_REFRACTORY_EN
                    cnt_q[idx] <= cnt_next;
`endif
                    // Publish on entry to DONE so out_valid is high during DONE.
                    if (idx == ADDR_W'(NUM_NEURONS - 1)) begin
                        out_spikes_q <= scratch_nx;
                        out_valid_q  <= 1'b1;
                        state        <= DONE;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array (4 neurons, 8-bit, leak >>3, threshold 200).
module tb_lif_neuron_array;
    import lif_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;

    lif_neuron_array_if #(.NUM_NEURONS(N), .WIDTH(W)) bus();

    lif_neuron_array #(
        .NUM_NEURONS  (N),
        .WIDTH        (W),
        .LEAK_SHIFT   (3),
        .THRESH_INIT  (200),
        .REFRAC_STEPS (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    int mv[N];
    int mw[N];
    int mth;
`ifdef LIF_REFRACTORY_EN
    int mcnt[N];
`endif
    logic [N-1:0] sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n] = 0;
            mw[n] = 0;
`ifdef LIF_REFRACTORY_EN
            mcnt[n] = 0;
`endif
        end
        mth = 200;
        sb.delete();
    endtask

    task automatic model_step(input logic [N-1:0] sp);
        logic [N-1:0] e;
        e = '0;
        for (int n = 0; n < N; n++) begin
            int t;
`ifdef LIF_REFRACTORY_EN
            if (mcnt[n] > 0) begin
                mcnt[n]--;
                continue;
            end
`endif
            t = mv[n] - (mv[n] >> 3) + (sp[n] ? mw[n] : 0);
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            if (t >= mth) begin
                e[n] = 1'b1;
                mv[n] = 0;
`ifdef LIF_REFRACTORY_EN
                mcnt[n] = 2;
`endif
            end else begin
                mv[n] = t;
            end
        end
        sb.push_back(e);
    endtask

    task automatic cfg_write(input logic sel, input logic [1:0] addr, input logic [W-1:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        if (sel == CFG_SEL_THRESH) mth = int'(data);
        else mw[addr] = int'($signed(data));
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic start_step(input logic [N-1:0] sp);
        bus.step_valid = 1'b1;
        bus.in_spikes  = sp;
        model_step(sp);
        tick();
        bus.step_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [N-1:0] got, output bit ok);
        ok  = 1'b0;
        got = 'x;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok  = 1'b1;
                got = bus.out_spikes;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        vecs++; if (bus.out_spikes !== 4'b0000) begin errs++; $display("FAIL reset_out_spikes: got %b expected 0000", bus.out_spikes); end
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        vecs++; if (bus.step_ready !== 1'b1) begin errs++; $display("FAIL reset_step_ready: got %b expected 1", bus.step_ready); end
        vecs++; if (bus.cfg_err !== 1'b0) begin errs++; $display("FAIL reset_cfg_err: got %b expected 0", bus.cfg_err); end
    endtask

    // V0: 100 -> 188 -> 265 clamps to 255 and fires; the fire zeroes V0.
    task automatic test_integrate(input string tag);
        logic [N-1:0] got, exp;
        logic [N-1:0] hand [3];
        bit ok;
        hand[0] = 4'b0000; hand[1] = 4'b0000; hand[2] = 4'b0001;
        cfg_write(CFG_SEL_WEIGHT, 2'd0, 8'd100);
        for (int s = 0; s < 3; s++) begin
            start_step(4'b0001);
            wait_out(got, ok);
            exp = sb.pop_front();
            vecs++; if (!ok || got !== exp) begin errs++; $display("FAIL %s_model step%0d: got %b (valid seen %0d) expected %b", tag, s, got, ok, exp); end
            vecs++; if (!ok || got !== hand[s]) begin errs++; $display("FAIL %s_hand step%0d: got %b expected %b", tag, s, got, hand[s]); end
        end
        // A surviving 255 would fire again; a zeroed V0 reaches only 100.
        start_step(4'b0001);
        wait_out(got, ok);
        exp = sb.pop_front();
        vecs++; if (!ok || got !== 4'b0000 || got !== exp) begin errs++; $display("FAIL %s_after_fire: got %b expected %b", tag, got, exp); end
    endtask

    task automatic test_latency();
        logic [N-1:0] exp;
        bus.step_valid = 1'b1;
        bus.in_spikes  = 4'b0000;
        model_step(4'b0000);
        tick();
        // Held valid while busy: must not be taken as a second step.
        bus.in_spikes = 4'b1111;
        for (int c = 1; c <= 6; c++) begin
            if (c == 5) bus.step_valid = 1'b0;
            vecs++; if (bus.step_ready !== (c == 6)) begin errs++; $display("FAIL latency_ready cycle%0d: got %b expected %b", c, bus.step_ready, (c == 6)); end
            vecs++; if (bus.out_valid !== (c == 5)) begin errs++; $display("FAIL latency_valid cycle%0d: got %b expected %b", c, bus.out_valid, (c == 5)); end
            if (c == 5) begin
                exp = sb.pop_front();
                vecs++; if (bus.out_spikes !== exp) begin errs++; $display("FAIL latency_spikes: got %b expected %b", bus.out_spikes, exp); end
            end
            if (c < 6) tick();
        end
    endtask

    task automatic test_neg_weight();
        logic [N-1:0] got, exp;
        bit ok;
        cfg_write(CFG_SEL_WEIGHT, 2'd1, 8'hCE);
        for (int s = 0; s < 2; s++) begin
            // A wrapped -50 would read as 206 and fire against 200.
            start_step(4'b0010);
            wait_out(got, ok);
            exp = sb.pop_front();
            vecs++; if (!ok || got !== exp || got[1] !== 1'b0) begin errs++; $display("FAIL neg_clamp step%0d: got %b expected %b", s, got, exp); end
        end
        cfg_write(CFG_SEL_WEIGHT, 2'd1, 8'd127);
        cfg_write(CFG_SEL_THRESH, 2'd0, 8'd100);
        start_step(4'b0010);
        wait_out(got, ok);
        exp = sb.pop_front();
        vecs++; if (!ok || got !== exp || got !== 4'b0010) begin errs++; $display("FAIL pos_fire: got %b expected %b", got, exp); end
    endtask

    task automatic test_cfg_err();
        logic [N-1:0] got, exp;
        bit ok;
        start_step(4'b0011);
        bus.cfg_we = 1'b1; bus.cfg_sel = CFG_SEL_WEIGHT; bus.cfg_addr = 2'd0; bus.cfg_data = 8'd0;
        tick();
        bus.cfg_we = 1'b0;
        vecs++; if (bus.cfg_err !== 1'b1) begin errs++; $display("FAIL cfg_err_update: got %b expected 1", bus.cfg_err); end
        tick();
        vecs++; if (bus.cfg_err !== 1'b0) begin errs++; $display("FAIL cfg_err_one_cycle: got %b expected 0", bus.cfg_err); end
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (bus.out_valid === 1'b1) ok = 1'b1;
            else tick();
        end
        got = bus.out_spikes;
        bus.cfg_we = 1'b1; bus.cfg_sel = CFG_SEL_THRESH; bus.cfg_data = 8'd0;
        tick();
        bus.cfg_we = 1'b0;
        vecs++; if (bus.cfg_err !== 1'b1) begin errs++; $display("FAIL cfg_err_done: got %b expected 1", bus.cfg_err); end
        exp = sb.pop_front();
        vecs++; if (!ok || got !== exp) begin errs++; $display("FAIL cfg_err_step: got %b expected %b", got, exp); end
        // Dropped weight/threshold writes would change this firing pattern.
        start_step(4'b0001);
        wait_out(got, ok);
        exp = sb.pop_front();
        vecs++; if (!ok || got !== exp) begin errs++; $display("FAIL cfg_readback: got %b expected %b", got, exp); end
        cfg_write(CFG_SEL_WEIGHT, 2'd2, 8'd0);
        vecs++; if (bus.cfg_err !== 1'b0) begin errs++; $display("FAIL cfg_err_idle_ok: got %b expected 0", bus.cfg_err); end
    endtask

    task automatic test_thresh_zero();
        logic [N-1:0] got, exp;
        bit ok;
        // Written in the handshake cycle: applies to this very step.
        bus.cfg_we = 1'b1; bus.cfg_sel = CFG_SEL_THRESH; bus.cfg_addr = 2'd0; bus.cfg_data = 8'd0;
        mth = 0;
        start_step(4'b0000);
        bus.cfg_we = 1'b0;
        wait_out(got, ok);
        exp = sb.pop_front();
        vecs++; if (!ok || got !== exp) begin errs++; $display("FAIL thresh_zero: got %b expected %b", got, exp); end
    endtask

    task automatic test_async_reset();
        bus.step_valid = 1'b1;
        bus.in_spikes  = 4'b1111;
        tick();
        bus.step_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vecs++; if (bus.out_spikes !== 4'b0000) begin errs++; $display("FAIL areset_out_spikes: got %b expected 0000", bus.out_spikes); end
        vecs++; if (bus.step_ready !== 1'b1) begin errs++; $display("FAIL areset_step_ready: got %b expected 1", bus.step_ready); end
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL areset_out_valid: got %b expected 0", bus.out_valid); end
        vecs++; if (bus.cfg_err !== 1'b0) begin errs++; $display("FAIL areset_cfg_err: got %b expected 0", bus.cfg_err); end
        tick();
        rst_n = 1'b1;
        model_reset();
        test_integrate("fresh");
    endtask

    task automatic test_ena();
        logic [N-1:0] got, exp;
        bit ok;
        start_step(4'b0001);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (bus.step_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL ena_freeze cycle%0d: got ready %b valid %b expected 0 0", i, bus.step_ready, bus.out_valid); end
        end
        ena = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (bus.out_valid === 1'b1) ok = 1'b1;
            else tick();
        end
        got = bus.out_spikes;
        ena = 1'b0;
        #1;
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL ena_masks_valid: got %b expected 0", bus.out_valid); end
        ena = 1'b1;
        tick();
        exp = sb.pop_front();
        vecs++; if (!ok || got !== exp) begin errs++; $display("FAIL ena_step: got %b expected %b", got, exp); end
        ena = 1'b0;
        bus.step_valid = 1'b1;
        bus.in_spikes  = 4'b1111;
        tick();
        tick();
        vecs++; if (bus.step_ready !== 1'b1) begin errs++; $display("FAIL ena_idle_hold: got %b expected 1", bus.step_ready); end
        bus.step_valid = 1'b0;
        ena = 1'b1;
        tick();
    endtask

    task automatic test_refractory();
        logic [N-1:0] got, exp, hand;
        bit ok;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        cfg_write(CFG_SEL_WEIGHT, 2'd0, 8'd127);
        cfg_write(CFG_SEL_THRESH, 2'd0, 8'd100);
        for (int s = 0; s < 7; s++) begin
`ifdef LIF_REFRACTORY_EN
            hand = (s % 3 == 0) ? 4'b0001 : 4'b0000;
`else
            hand = 4'b0001;
`endif
            start_step(4'b0001);
            wait_out(got, ok);
            exp = sb.pop_front();
            vecs++; if (!ok || got !== hand) begin errs++; $display("FAIL refrac_hand step%0d: got %b expected %b", s + 1, got, hand); end
            vecs++; if (!ok || got !== exp) begin errs++; $display("FAIL refrac_model step%0d: got %b expected %b", s + 1, got, exp); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.step_valid = 1'b0;
        bus.in_spikes  = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_sel    = CFG_SEL_WEIGHT;
        bus.cfg_addr   = '0;
        bus.cfg_data   = '0;
        test_reset();
        test_integrate("integrate");
        test_latency();
        test_neg_weight();
        test_cfg_err();
        test_thresh_zero();
        test_async_reset();
        test_ena();
        test_refractory();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
